// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag nibble bit positions and sequential-unit state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Negative/zero flag derivation from an ALU result word.
// Latency: combinational.
// Backpressure: none.
module alu_flag_gen #(
    parameter int size = 16
) (
    input  logic [size-1:0] result,
    output logic            n,
    output logic            z
);

    assign n = result[size-1];
    assign z = ~|result;

endmodule

// File: rtl/left_shifter_seq.sv
// Multi-cycle logical left shifter, one bit per clock, with N/Z/V/C flags.
// Latency: shift+1 cycles from accepted start to done (1 cycle when shift is 0).
// Backpressure: start is sampled only while idle; start during busy is dropped.
module left_shifter_seq
    import alu_pkg::*;
#(
    parameter int size = 16,
    parameter int m    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [size-1:0] in_a,
    input  logic [m-1:0]    shift,
    output logic [size-1:0] out,
    output logic [3:0]      flags_n_z_v_c,
    output logic            busy,
    output logic            done
);

    state_t          state_q, state_d;
    logic [size-1:0] work_q, work_d;
    logic [m-1:0]    cnt_q, cnt_d;
    logic            sign0_q, sign0_d;
    logic            v_q, v_d;
    logic            c_q, c_d;
    logic            n_d, z_d;
    logic [3:0]      flags_d;

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        sign0_d = sign0_q;
        v_d     = v_q;
        c_d     = c_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d  = in_a;
                    cnt_d   = shift;
                    sign0_d = in_a[size-1];
                    v_d     = 1'b0;
                    c_d     = 1'b0;
                    state_d = (shift != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                // Overflow tracks any step where the bit moving into the sign slot disagrees with the original sign.
                c_d    = work_q[size-1];
                work_d = {work_q[size-2:0], 1'b0};
                v_d    = v_q | (work_q[size-2] != sign0_q);
                cnt_d  = cnt_q - m'(1);
                if (cnt_q == m'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    alu_flag_gen #(
        .size(size)
    ) u_flag_gen (
        .result(work_d),
        .n     (n_d),
        .z     (z_d)
    );

    always_comb begin
        flags_d         = 4'b0000;
        flags_d[FLAG_N] = n_d;
        flags_d[FLAG_Z] = z_d;
        flags_d[FLAG_V] = v_d;
        flags_d[FLAG_C] = c_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            work_q        <= '0;
            cnt_q         <= '0;
            sign0_q       <= 1'b0;
            v_q           <= 1'b0;
            c_q           <= 1'b0;
            out           <= '0;
            flags_n_z_v_c <= 4'b0000;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            sign0_q <= sign0_d;
            v_q     <= v_d;
            c_q     <= c_d;
            busy    <= (state_d != ST_IDLE);
            done    <= (state_d == ST_DONE);
            // Result is published on the edge entering DONE and then held through IDLE.
            if (state_d == ST_DONE) begin
                out           <= work_d;
                flags_n_z_v_c <= flags_d;
            end
        end
    end

endmodule
